// File: rtl/ahb_lite_sram_slave_pkg.sv
// Shared encodings for the AHB-Lite SRAM slave:
// bus field values, FSM states and the byte-lane decoder.
`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif

package ahb_lite_sram_slave_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } state_t;

  // Little-endian lane enables for one transfer.
  function automatic logic [3:0] lane_mask(
    input logic [2:0] size,
    input logic [1:0] off
  );
    logic [3:0] m;
    m = 4'b0000;
    unique case (1'b1)
      size == HSIZE_BYTE: m = 4'b0001 << off;
      size == HSIZE_HALF: m = off[1] ? 4'b1100 : 4'b0011;
      size == HSIZE_WORD: m = 4'b1111;
      default:            m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ahb_lite_sram_slave_if.sv
// AHB-Lite slot bundle between the bus fabric and one slave.
// The master side also returns the fabric-wide HREADY.
`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif

interface ahb_lite_sram_slave_if;
  logic                  HSEL;
  logic [`BUS_WIDTH-1:0] HADDR;
  logic [1:0]            HTRANS;
  logic                  HWRITE;
  logic [2:0]            HSIZE;
  logic [`BUS_WIDTH-1:0] HWDATA;
  logic                  HREADY;
  logic [`BUS_WIDTH-1:0] HRDATA;
  logic                  HREADYOUT;
  logic                  HRESP;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE,
    output HSIZE, HWDATA, HREADY,
    input  HRDATA, HREADYOUT, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE,
    input  HSIZE, HWDATA, HREADY,
    output HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/ahb_lite_sram_array.sv
// Word-wide SRAM with per-byte write enables
// and an asynchronous read port.
`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif

module ahb_lite_sram_array #(
  parameter int ADDR_BITS = 10
) (
  input  logic                  clk,
  input  logic [ADDR_BITS-1:0]  addr,
  input  logic [3:0]            we,
  input  logic [`BUS_WIDTH-1:0] wdata,
  output logic [`BUS_WIDTH-1:0] rdata
);
  localparam int LANE = `BUS_WIDTH / 4;

  logic [`BUS_WIDTH-1:0] mem [2**ADDR_BITS];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) begin
        mem[addr][i*LANE +: LANE] <= wdata[i*LANE +: LANE];
      end
    end
  end

  assign rdata = mem[addr];
endmodule

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite SRAM slave: address-phase capture,
// wait/error FSM and byte-lane write control.
`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif

module ahb_lite_sram_slave
  import ahb_lite_sram_slave_pkg::*;
#(
  parameter int ADDR_BITS   = 10,
  parameter int WAIT_STATES = 0
) (
  input logic                  HCLK,
  input logic                  HRESETn,
  ahb_lite_sram_slave_if.slave bus
);
  state_t                state;
  logic [3:0]            cnt;
  logic [ADDR_BITS-1:0]  addr_q;
  logic                  write_q;
  logic [2:0]            size_q;
  logic [1:0]            off_q;
  logic                  ready_q;
  logic                  resp_q;
  logic                  accept;
  logic                  err;
  logic [3:0]            we;
  logic [`BUS_WIDTH-1:0] rdata;
  logic                  unused;

  assign accept = bus.HSEL & bus.HREADY & bus.HTRANS[1];

  assign err = (bus.HSIZE > HSIZE_WORD)
             | (|bus.HADDR[27:ADDR_BITS+2])
             | ((bus.HSIZE == HSIZE_HALF) & bus.HADDR[0])
             | ((bus.HSIZE == HSIZE_WORD) & (|bus.HADDR[1:0]));

  assign unused = ^{bus.HADDR[`BUS_WIDTH-1:28], bus.HTRANS[0]};

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state   <= ST_IDLE;
      cnt     <= 4'd0;
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= 3'd0;
      off_q   <= 2'd0;
      ready_q <= 1'b1;
      resp_q  <= HRESP_OKAY;
    end else begin
      unique case (state)
        ST_WAIT: begin
          if (cnt == 4'd0) begin
            state   <= ST_DATA;
            ready_q <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_ERR1: begin
          state   <= ST_ERR2;
          ready_q <= 1'b1;
        end
        // IDLE, DATA and ERR2 all end with HREADYOUT high
        default: begin
          if (accept) begin
            addr_q  <= bus.HADDR[ADDR_BITS+1:2];
            write_q <= bus.HWRITE;
            size_q  <= bus.HSIZE;
            off_q   <= bus.HADDR[1:0];
            if (err) begin
              state   <= ST_ERR1;
              ready_q <= 1'b0;
              resp_q  <= HRESP_ERROR;
            end else if (WAIT_STATES > 0) begin
              state   <= ST_WAIT;
              cnt     <= 4'(WAIT_STATES - 1);
              ready_q <= 1'b0;
              resp_q  <= HRESP_OKAY;
            end else begin
              state   <= ST_DATA;
              ready_q <= 1'b1;
              resp_q  <= HRESP_OKAY;
            end
          end else begin
            state   <= ST_IDLE;
            ready_q <= 1'b1;
            resp_q  <= HRESP_OKAY;
          end
        end
      endcase
    end
  end

  assign we = (state == ST_DATA && write_q)
            ? lane_mask(size_q, off_q) : 4'b0000;

  ahb_lite_sram_array #(
    .ADDR_BITS(ADDR_BITS)
  ) u_array (
    .clk  (HCLK),
    .addr (addr_q),
    .we   (we),
    .wdata(bus.HWDATA),
    .rdata(rdata)
  );

  assign bus.HRDATA = (!write_q && (state == ST_WAIT || state == ST_DATA))
                    ? rdata : '0;
  assign bus.HREADYOUT = ready_q;
  assign bus.HRESP     = resp_q;
endmodule
